tsw_conditioner: RTL and testbench



---
 rtl/tsw_pkg.sv | 20 ++
 rtl/tsw_key.sv | 146 ++++++++++++++
 rtl/tsw_conditioner.sv | 64 ++++++
 tb/tb_tsw_conditioner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsw_pkg.sv
// Shared constants for the tact-switch conditioner: key indices, repeat-state
// encoding and a small helper used to size the repeat counter.
package tsw_pkg;

  localparam int unsigned NUM_KEYS = 8;

  localparam int unsigned KEY_MIN_UP  = 0;
  localparam int unsigned KEY_HOUR_UP = 1;
  localparam int unsigned KEY_MODE    = 2;
  localparam int unsigned KEY_CLR     = 3;

  localparam logic [1:0] RPT_IDLE   = 2'd0;
  localparam logic [1:0] RPT_DELAY  = 2'd1;
  localparam logic [1:0] RPT_REPEAT = 2'd2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tsw_key.sv
// One key: two-flop synchroniser, tick-based debounce and, when
// TSW_AUTOREPEAT_EN is defined, the press/auto-repeat step FSM.
module tsw_key
  import tsw_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 10
`ifdef TSW_AUTOREPEAT_EN
  ,
  parameter int unsigned RPT_DELAY = 500,
  parameter int unsigned RPT_RATE  = 150
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic tsw_n_i,
  output logic lvl_o,
  output logic prs_o,
  output logic rel_o,
  output logic rpt_o
);

  localparam int unsigned DW = $clog2(DEB_TICKS + 1);

  logic          s1_q, s2_q;
  logic          sync;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          prs_q, prs_d;
  logic          rel_q, rel_d;

  // Synchroniser idles at 1 (released) so reset never fakes a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= tsw_n_i;
      s2_q <= s1_q;
    end
  end

  assign sync = ~s2_q;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    prs_d = 1'b0;
    rel_d = 1'b0;
    if (sync == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == DW'(DEB_TICKS - 1)) begin
        lvl_d = ~lvl_q;
        cnt_d = '0;
        prs_d = sync;
        rel_d = ~sync;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
      prs_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      rel_q <= rel_d;
    end
  end

  assign lvl_o = lvl_q;
  assign prs_o = prs_q;
  assign rel_o = rel_q;

`ifdef TSW_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(max_u(RPT_DELAY, RPT_RATE) + 1);

  logic [1:0]    st_q, st_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rpt_q, rpt_d;

  // Release wins over everything and never emits a step in its own cycle.
  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    rpt_d  = 1'b0;
    if (rel_d) begin
      st_d   = tsw_pkg::RPT_IDLE;
      rcnt_d = '0;
    end else if (prs_d) begin
      st_d   = tsw_pkg::RPT_DELAY;
      rcnt_d = '0;
      rpt_d  = 1'b1;
    end else begin
      case (st_q)
        tsw_pkg::RPT_DELAY: begin
          if (tick_i) begin
            if (rcnt_q == RW'(RPT_DELAY - 1)) begin
              rpt_d  = 1'b1;
              rcnt_d = '0;
              st_d   = tsw_pkg::RPT_REPEAT;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
        end
        tsw_pkg::RPT_REPEAT: begin
          if (tick_i) begin
            if (rcnt_q == RW'(RPT_RATE - 1)) begin
              rpt_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= tsw_pkg::RPT_IDLE;
      rcnt_q <= '0;
      rpt_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      rcnt_q <= rcnt_d;
      rpt_q  <= rpt_d;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = prs_q;
`endif

endmodule

// File: rtl/tsw_conditioner.sv
// Conditions the 8 active-low tact switches: shared sample-tick prescaler plus
// one tsw_key per switch. Auto-repeat is built only with TSW_AUTOREPEAT_EN.
module tsw_conditioner
  import tsw_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 10,
  parameter int unsigned RPT_DELAY = 500,
  parameter int unsigned RPT_RATE  = 150
) (
  input  logic       pCLK,
  input  logic       pRST,
  input  logic [7:0] TSW,
  output logic [7:0] KEY_LVL,
  output logic [7:0] KEY_PRS,
  output logic [7:0] KEY_REL,
  output logic [7:0] KEY_RPT
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  if (TICK_DIV < 2 || DEB_TICKS < 1 || RPT_DELAY < 1 || RPT_RATE < 1) begin : g_param_err
    $error("tsw_conditioner: illegal parameter values");
  end

  logic [TW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (pre_q == TW'(TICK_DIV - 1));
    pre_d  = tick_d ? '0 : pre_q + TW'(1);
  end

  always_ff @(posedge pCLK) begin
    if (pRST) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    tsw_key #(
      .DEB_TICKS(DEB_TICKS)
`ifdef TSW_AUTOREPEAT_EN
      ,
      .RPT_DELAY(RPT_DELAY),
      .RPT_RATE (RPT_RATE)
`endif
    ) u_key (
      .clk_i  (pCLK),
      .rst_i  (pRST),
      .tick_i (tick_q),
      .tsw_n_i(TSW[i]),
      .lvl_o  (KEY_LVL[i]),
      .prs_o  (KEY_PRS[i]),
      .rel_o  (KEY_REL[i]),
      .rpt_o  (KEY_RPT[i])
    );
  end

endmodule

// File: tb/tb_tsw_conditioner.sv
// Bench for tsw_conditioner: directed scenarios plus random bouncing input,
// checked every cycle against a tick/delay-line model of the key behaviour.
module tb_tsw_conditioner;
  import tsw_pkg::*;

  localparam int unsigned TD  = 4;
  localparam int unsigned DEB = 3;
  localparam int unsigned RD  = 10;
  localparam int unsigned RR  = 4;

  logic       pCLK = 1'b0;
  logic       pRST = 1'b1;
  logic [7:0] TSW  = 8'hFF;
  logic [7:0] KEY_LVL, KEY_PRS, KEY_REL, KEY_RPT;

  int checks   = 0;
  int failures = 0;

  tsw_conditioner #(
    .TICK_DIV (TD),
    .DEB_TICKS(DEB),
    .RPT_DELAY(RD),
    .RPT_RATE (RR)
  ) dut (
    .pCLK   (pCLK),
    .pRST   (pRST),
    .TSW    (TSW),
    .KEY_LVL(KEY_LVL),
    .KEY_PRS(KEY_PRS),
    .KEY_REL(KEY_REL),
    .KEY_RPT(KEY_RPT)
  );

  always #5 pCLK = ~pCLK;

  // ---------------- reference model ----------------
  logic [7:0] m_lvl = '0, m_prs = '0, m_rel = '0, m_rpt = '0;
  logic [7:0] raw_dly[2];
  int         dcnt[8];
  int         tsp[8];
  bit         held[8];
  int         k = 0;
  bit         model_ok = 1'b0;

  task automatic model_step();
    bit         tick;
    logic [7:0] pressed;
    if (pRST) begin
      k = 0;
      raw_dly[0] = 8'hFF;
      raw_dly[1] = 8'hFF;
      m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0;
      for (int i = 0; i < 8; i++) begin
        dcnt[i] = 0; tsp[i] = 0; held[i] = 1'b0;
      end
      model_ok = 1'b1;
    end else begin
      // Tick is visible after every TD-th clock since reset; raw seen 2 edges late.
      tick    = (k > 0) && (k % TD == 0);
      pressed = ~raw_dly[1];
      m_prs = '0; m_rel = '0; m_rpt = '0;
      for (int i = 0; i < 8; i++) begin
        if (pressed[i] == m_lvl[i]) begin
          dcnt[i] = 0;
        end else if (tick) begin
          dcnt[i]++;
          if (dcnt[i] == DEB) begin
            m_lvl[i] = ~m_lvl[i];
            dcnt[i]  = 0;
            if (m_lvl[i]) m_prs[i] = 1'b1;
            else          m_rel[i] = 1'b1;
          end
        end
`ifdef TSW_AUTOREPEAT_EN
        if (m_prs[i]) begin
          m_rpt[i] = 1'b1; held[i] = 1'b1; tsp[i] = 0;
        end else if (m_rel[i]) begin
          held[i] = 1'b0;
        end else if (held[i] && tick) begin
          tsp[i]++;
          if (tsp[i] == RD || (tsp[i] > RD && (tsp[i] - RD) % RR == 0))
            m_rpt[i] = 1'b1;
        end
`else
        m_rpt[i] = m_prs[i];
`endif
      end
      raw_dly[1] = raw_dly[0];
      raw_dly[0] = TSW;
      k++;
    end
  endtask

  initial forever begin
    @(posedge pCLK);
    model_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d t=%0t", name, act, lo, hi, $time);
    end
  endtask

  initial forever begin
    @(negedge pCLK);
    if (model_ok) begin
      chk_vec("model_lvl", KEY_LVL, m_lvl);
      chk_vec("model_prs", KEY_PRS, m_prs);
      chk_vec("model_rel", KEY_REL, m_rel);
      chk_vec("model_rpt", KEY_RPT, m_rpt);
    end
  end

  function automatic logic [7:0] sel(input int s);
    case (s)
      0:       return KEY_LVL;
      1:       return KEY_PRS;
      2:       return KEY_REL;
      default: return KEY_RPT;
    endcase
  endfunction

  // Cycles until output group s has bit b high; -1 when the budget expires.
  task automatic wait_sig(input int s, input int b, input int budget, output int n);
    logic [7:0] v;
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge pCLK);
      v = sel(s);
      if (v[b] === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    int hold;
    int exp_cnt;
    int rate;
    bit seen;
    int times[$];

    pRST = 1'b1;
    TSW  = 8'h00;
    repeat (5) @(negedge pCLK);
    chk_vec("reset_lvl", KEY_LVL, 8'h00);
    chk_vec("reset_pulses", KEY_PRS | KEY_REL | KEY_RPT, 8'h00);

    // All keys held through reset: fresh press after full debounce latency.
    pRST = 1'b0;
    wait_sig(0, 0, 40, n);
    chk_rng("reset_release_lat", n, 11, 14);
    chk_vec("reset_release_lvl", KEY_LVL, 8'hFF);
    chk_vec("reset_release_prs", KEY_PRS, 8'hFF);
    chk_vec("model_pin_lvl", m_lvl, 8'hFF);
    @(negedge pCLK);
    chk_vec("prs_width", KEY_PRS, 8'h00);

    TSW = 8'hFF;
    wait_sig(2, 0, 40, n);
    chk_rng("all_release_lat", n, 11, 14);
    chk_vec("all_release_rel", KEY_REL, 8'hFF);
    repeat (20) @(negedge pCLK);

    // Clean press of minute+, held 200 cycles.
    TSW[KEY_MIN_UP] = 1'b0;
    wait_sig(1, KEY_MIN_UP, 40, n);
    chk_rng("press_lat", n, 11, 14);
    chk_vec("press_lvl", KEY_LVL, 8'h01);
    chk_vec("press_rpt", KEY_RPT, 8'h01);
    chk_vec("model_pin_prs", m_prs, 8'h01);
    if (n < 0) n = 40;
    hold = 200 - n;
    times.delete();
    times.push_back(0);
    for (int c = 1; c <= hold; c++) begin
      @(negedge pCLK);
      if (KEY_RPT[KEY_MIN_UP] === 1'b1) times.push_back(c);
    end
`ifdef TSW_AUTOREPEAT_EN
    chk_rng("rpt_first_gap", (times.size() > 1) ? times[1] - times[0] : -1, 40, 40);
    chk_rng("rpt_second_gap", (times.size() > 2) ? times[2] - times[1] : -1, 16, 16);
    exp_cnt = 1 + ((hold >= 40) ? 1 + (hold - 40) / 16 : 0);
    chk_rng("rpt_count", times.size(), exp_cnt, exp_cnt);
`else
    chk_rng("rpt_count", times.size(), 1, 1);
`endif

    TSW[KEY_MIN_UP] = 1'b1;
    wait_sig(2, KEY_MIN_UP, 40, n);
    chk_rng("release_lat", n, 11, 14);
    chk_vec("release_rpt", KEY_RPT, 8'h00);
    cnt = 0;
    repeat (30) begin
      @(negedge pCLK);
      if (KEY_RPT[KEY_MIN_UP] === 1'b1) cnt++;
    end
    chk_rng("rpt_after_release", cnt, 0, 0);

    // Bounce on hour+: 5-cycle segments never last DEB ticks.
    seen = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      TSW[KEY_HOUR_UP] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) begin
        @(negedge pCLK);
        if (KEY_LVL[KEY_HOUR_UP] !== 1'b0 || KEY_PRS[KEY_HOUR_UP] !== 1'b0 ||
            KEY_REL[KEY_HOUR_UP] !== 1'b0) seen = 1'b1;
      end
    end
    TSW[KEY_HOUR_UP] = 1'b1;
    repeat (20) begin
      @(negedge pCLK);
      if (KEY_LVL[KEY_HOUR_UP] !== 1'b0 || KEY_PRS[KEY_HOUR_UP] !== 1'b0 ||
          KEY_REL[KEY_HOUR_UP] !== 1'b0) seen = 1'b1;
    end
    chk_rng("bounce_quiet", int'(seen), 0, 0);

    // Reset while mode key sits in the repeat phase.
    TSW[KEY_MODE] = 1'b0;
    wait_sig(1, KEY_MODE, 40, n);
    chk_rng("mode_press_lat", n, 11, 14);
    repeat (50) @(negedge pCLK);
    pRST = 1'b1;
    @(negedge pCLK);
    pRST = 1'b0;
    chk_vec("midhold_clear_lvl", KEY_LVL, 8'h00);
    chk_vec("midhold_clear_pulses", KEY_PRS | KEY_REL | KEY_RPT, 8'h00);
    wait_sig(1, KEY_MODE, 40, n);
    chk_rng("midhold_repress_lat", n, 11, 14);
    chk_vec("midhold_repress_lvl", KEY_LVL, 8'h04);
    TSW = 8'hFF;
    repeat (40) @(negedge pCLK);

    // Random regimes: heavy bounce or slow, long holds on every key.
    for (int seg = 0; seg < 15; seg++) begin
      rate = ($urandom_range(0, 1) == 0) ? 4 : 60;
      repeat (200) begin
        @(negedge pCLK);
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, rate - 1) == 0) TSW[b] = ~TSW[b];
      end
    end
    TSW = 8'hFF;
    repeat (60) @(negedge pCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
